// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches opcode plus optional immediate word, hands off to the CU.
// Optional HALT opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter int unsigned     PC_W     = 10,
  parameter int unsigned     DATA_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] imm,
  output logic [PC_W-1:0]   pc,
  output logic              instr_valid,
  input  logic              issue_ready,
  input  logic              branch,
  input  logic [PC_W-1:0]   branch_target,
  output logic              halted
);

  localparam int unsigned OP_W = 6;

  localparam logic [2:0] ST_RST       = 3'd0;
  localparam logic [2:0] ST_FETCH_I   = 3'd1;
  localparam logic [2:0] ST_FETCH_IMM = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
`ifdef FETCH_HALT_EN
  localparam logic [2:0] ST_HALT      = 3'd4;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;
`endif

  logic [2:0]        state, state_next;
  logic [PC_W-1:0]   fetch_ptr, fetch_ptr_next;
  logic [PC_W-1:0]   pc_next;
  logic [DATA_W-1:0] instruction_next, imm_next;
  logic              mem_hit;

  // INP and the branch/jump family carry a second immediate word
  function automatic logic is_two_word(input logic [OP_W-1:0] op);
    return (op == 6'd26) || ((op >= 6'd32) && (op <= 6'd37));
  endfunction

  assign mem_addr = fetch_ptr;
  assign mem_hit  = mem_req && mem_valid;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_RST;
      fetch_ptr   <= RESET_PC;
      pc          <= RESET_PC;
      instruction <= '0;
      imm         <= '0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_ptr   <= fetch_ptr_next;
      pc          <= pc_next;
      instruction <= instruction_next;
      imm         <= imm_next;
      instr_valid <= (state_next == ST_ISSUE);
      mem_req     <= (state_next == ST_FETCH_I) || (state_next == ST_FETCH_IMM);
    end
  end

  always_comb begin
    state_next       = state;
    fetch_ptr_next   = fetch_ptr;
    pc_next          = pc;
    instruction_next = instruction;
    imm_next         = imm;
    case (state)
      ST_RST: state_next = ST_FETCH_I;
      ST_FETCH_I: begin
        if (mem_hit) begin
          instruction_next = mem_rdata;
          pc_next          = fetch_ptr;
          fetch_ptr_next   = fetch_ptr + PC_W'(1);
          if (is_two_word(mem_rdata[DATA_W-1 -: OP_W])) begin
            state_next = ST_FETCH_IMM;
          end else begin
            imm_next   = '0;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_FETCH_IMM: begin
        if (mem_hit) begin
          imm_next       = mem_rdata;
          fetch_ptr_next = fetch_ptr + PC_W'(1);
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
`ifdef FETCH_HALT_EN
          if (instruction[DATA_W-1 -: OP_W] == OP_HALT) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_FETCH_I;
            if (branch) fetch_ptr_next = branch_target;
          end
`else
          state_next = ST_FETCH_I;
          if (branch) fetch_ptr_next = branch_target;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: state_next = ST_HALT;
`endif
      default: state_next = ST_RST;
    endcase
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) halted <= 1'b0;
    else        halted <= (state_next == ST_HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: chained directed vectors plus wait-state and reset corner sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] instruction;
  logic [15:0] imm;
  logic [9:0]  pc;
  logic        instr_valid;
  logic        issue_ready = 1'b0;
  logic        branch = 1'b0;
  logic [9:0]  branch_target = '0;
  logic        halted;

  fetch_unit dut (
    .clk(clk), .rst_b(rst_b),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instruction(instruction), .imm(imm), .pc(pc), .instr_valid(instr_valid),
    .issue_ready(issue_ready), .branch(branch), .branch_target(branch_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory model: programmable wait states, plus a spurious-valid injector
  logic [15:0] mem [1024];
  int          mem_lat = 0;
  int          wait_cnt;
  logic        spurious = 1'b0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b)                      wait_cnt <= 0;
    else if (mem_req && !mem_valid)  wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end
  assign mem_valid = (mem_req && (wait_cnt >= mem_lat)) || spurious;
  assign mem_rdata = mem[mem_addr];

  int issues = 0;
  always @(posedge clk) if (instr_valid && issue_ready) issues <= issues + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        br;
    logic [9:0]  tgt;
    int          lat;      // edges from mem_req rising to instr_valid
    logic [15:0] exp_imm;
    logic [9:0]  exp_next;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v);
    logic [9:0] a1;
    int n;
    a1 = v.addr + 10'd1;
    mem[v.addr] = v.w0;
    mem[a1]     = v.w1;
    chk("fetch_addr", {21'd0, mem_req, mem_addr}, {21'd0, 1'b1, v.addr});
    wait_valid(n);
    chk("latency", 32'(n), 32'(v.lat));
    chk("instruction", 32'(instruction), 32'(v.w0));
    chk("imm", 32'(imm), 32'(v.exp_imm));
    chk("pc", 32'(pc), 32'(v.addr));
    branch = v.br;
    branch_target = v.tgt;
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    branch = 1'b0;
    branch_target = 10'h2AA;
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    int n;
    int issues0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

    vecs[0]  = '{10'h000, 16'h4800, 16'h0000, 1'b0, 10'h000, 1, 16'h0000, 10'h001};
    vecs[1]  = '{10'h001, 16'h4800, 16'h0000, 1'b1, 10'h004, 1, 16'h0000, 10'h004};
    vecs[2]  = '{10'h004, 16'h9000, 16'h0020, 1'b1, 10'h020, 2, 16'h0020, 10'h020};
    vecs[3]  = '{10'h020, 16'h1000, 16'h0000, 1'b1, 10'h006, 1, 16'h0000, 10'h006};
    vecs[4]  = '{10'h006, 16'h8000, 16'h0040, 1'b0, 10'h040, 2, 16'h0040, 10'h008};
    vecs[5]  = '{10'h008, 16'h4800, 16'h0000, 1'b1, 10'h3FF, 1, 16'h0000, 10'h3FF};
    vecs[6]  = '{10'h3FF, 16'h6800, 16'h1234, 1'b0, 10'h000, 2, 16'h1234, 10'h001};
    vecs[7]  = '{10'h001, 16'hFC00, 16'h0000, 1'b0, 10'h000, 1, 16'h0000, 10'h002};
    vecs[8]  = '{10'h002, 16'h8400, 16'hBEEF, 1'b1, 10'h155, 2, 16'hBEEF, 10'h155};
    vecs[9]  = '{10'h155, 16'h9C00, 16'h0000, 1'b0, 10'h000, 1, 16'h0000, 10'h156};
    vecs[10] = '{10'h156, 16'h9400, 16'h00AA, 1'b0, 10'h000, 2, 16'h00AA, 10'h158};
    vecs[11] = '{10'h158, 16'h6400, 16'h0000, 1'b0, 10'h000, 1, 16'h0000, 10'h159};

    #1 rst_b = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Three wait states per read on a two-word opcode, then a held-off issue
    mem_lat = 3;
    mem[10'h159] = 16'h8000;
    mem[10'h15A] = 16'h0077;
    issues0 = issues;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_addr", 32'(mem_addr), (k < 4) ? 32'h159 : 32'h15A);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    tick();
    chk("slow_valid", 32'(instr_valid), 32'd1);
    mem_lat = 0;
    spurious = 1'b1;
    branch = 1'b1;
    branch_target = 10'h2AA;
    mem[10'h15B] = 16'hDEAD;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_req", 32'(mem_req), 32'd0);
      chk("hold_instr", 32'(instruction), 32'h8000);
      chk("hold_imm", 32'(imm), 32'h0077);
      chk("hold_pc", 32'(pc), 32'h159);
    end
    spurious = 1'b0;
    branch = 1'b0;
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("one_issue", 32'(issues - issues0), 32'd1);
    chk("post_hold_addr", {21'd0, mem_req, mem_addr}, {21'd0, 1'b1, 10'h15B});

    // Reset while waiting on the immediate word
    mem[10'h15B] = 16'h8000;
    mem[10'h15C] = 16'h0011;
    tick();
    chk("imm_phase_addr", 32'(mem_addr), 32'h15C);
    rst_b = 1'b0;
    #2;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("refetch_addr", {21'd0, mem_req, mem_addr}, {21'd0, 1'b1, 10'h000});
    wait_valid(n);
    chk("refetch_lat", 32'(n), 32'd1);
    chk("refetch_instr", 32'(instruction), 32'h1234);
    chk("refetch_pc", 32'(pc), 32'h000);
    chk("halted_tied", 32'(halted), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
